regfile_mp: RTL

Parametrised multi-port integer register file with a per-register scoreboard and a post-reset clear sequencer; it replaces the single-write, two-read register bank in the decode stage. It provides NUM_RD combinational read ports and NUM_WR write ports. Same-cycle write-to-read bypass is compile-time selectable. Busy bits let issue logic stall on pending writes.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_scoreboard.sv | 46 ++++
 rtl/regfile_mp.sv | 130 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register file.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
package regfile_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREGS_DEF  = 32;
  localparam int NUM_RD_DEF = 2;
  localparam int NUM_WR_DEF = 1;
  localparam int AW_DEF     = $clog2(NREGS_DEF);

  // CLEAR walks the storage writing zeros; RUN is normal operation.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef logic [XLEN_DEF-1:0] data_t;
  typedef logic [AW_DEF-1:0]   addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits. A claim marks a register busy, a write
// retires it; when both hit the same register on one edge the claim wins,
// since it names a newer producer. Register 0 is never busy.
module regfile_scoreboard #(
  parameter  int NREGS  = 32,
  parameter  int NUM_WR = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WR-1:0]    i_clr_en,
  input  logic [NUM_WR*AW-1:0] i_clr_addr,
  input  logic                 i_set_en,
  input  logic [AW-1:0]        i_set_addr,
  output logic [NREGS-1:0]     o_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Next busy vector: retire writes first, then apply the claim on top.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NUM_WR; j++) begin
      if (i_clr_en[j]) begin
        w_busy_nxt[i_clr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (i_set_en) begin
      w_busy_nxt[i_set_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Busy register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with scoreboard and post-reset clear sequencer.
// After reset the CLEAR state zeroes registers 1..NREGS-1, one per cycle,
// then asserts ready. Define REGFILE_BYPASS_EN to forward same-cycle write
// data to matching read ports.
// Handshake: there is no valid/ready pairing on the ports; wr_en/claim_en
// are single-cycle strobes taken on any rising edge while ready is 1 and
// ignored otherwise; reads are combinational and always valid when ready.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREGS  = NREGS_DEF,
  parameter  int NUM_RD = NUM_RD_DEF,
  parameter  int NUM_WR = NUM_WR_DEF,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   claim_en,
  input  logic [AW-1:0]          claim_addr,
  output logic                   ready,
  output state_e                 dbg_state
);

  logic [XLEN-1:0]  r_regs [NREGS];
  state_e           r_state;
  logic [AW-1:0]    r_clr_ptr;
  logic             r_ready;

  logic             w_run;
  logic [NUM_WR-1:0] w_wr_live;
  logic             w_claim_live;
  logic [NREGS-1:0] w_busy;

  assign w_run = (r_state == RUN);

  // Writes to x0 and any strobe outside RUN never reach storage or the scoreboard.
  always_comb begin
    w_wr_live = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      w_wr_live[j] = wr_en[j] && w_run && (wr_addr[j*AW +: AW] != '0);
    end
  end

  assign w_claim_live = claim_en && w_run && (claim_addr != '0);

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr_en   (w_wr_live),
    .i_clr_addr (wr_addr),
    .i_set_en   (w_claim_live),
    .i_set_addr (claim_addr),
    .o_busy     (w_busy)
  );

  // Clear sequencer: restart at x1 on reset, hand over to RUN after the last register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_clr_ptr <= AW'(1);
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_ptr <= r_clr_ptr + AW'(1);
          if (r_clr_ptr == AW'(NREGS - 1)) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        RUN: begin
          r_state <= RUN;
        end
        default: begin
          r_state <= CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage: zero fill during CLEAR, port writes in RUN (higher port index wins).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == CLEAR) begin
        r_regs[r_clr_ptr] <= '0;
      end else begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (w_wr_live[j]) begin
            r_regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
          end
        end
      end
    end
  end

  // Read ports: x0 and the CLEAR phase read as zero and not busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (w_run && (rd_addr[i*AW +: AW] != '0)) begin
        rd_data[i*XLEN +: XLEN] = r_regs[rd_addr[i*AW +: AW]];
        rd_busy[i]              = w_busy[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NUM_WR; j++) begin
          if (w_wr_live[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
            rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
            rd_busy[i]              = 1'b0;
          end
        end
`endif
      end
    end
  end

  assign ready     = r_ready;
  assign dbg_state = r_state;

endmodule
